// File: rtl/instr_buffer_reader.sv
// Read-side controller for the ESM instruction buffer: tracks the circular-buffer pointers and
// occupancy, and presents one registered instruction at a time over a valid/ready handshake.
module instr_buffer_reader #(
  parameter int unsigned Instruction_word_size = 16,
  parameter int unsigned bs                    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  output logic [$clog2(bs)-1:0]            wr_index,
  output logic [$clog2(bs)-1:0]            rd_index,
  input  logic [Instruction_word_size-1:0] buf_data,
  output logic [Instruction_word_size-1:0] instr_out,
  output logic                             instr_valid,
  input  logic                             instr_ready,
  input  logic                             flush,
  output logic [$clog2(bs):0]              count,
  output logic                             empty,
  output logic                             full,
  output logic                             overflow
);

  localparam int unsigned AW     = $clog2(bs);
  localparam int unsigned CountW = AW + 1;
  localparam logic [AW:0] CountFull = CountW'(bs);

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e                           state_q, state_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [AW:0]                      count_q, count_d;
  logic [Instruction_word_size-1:0] instr_q, instr_d;
  logic                             overflow_q, overflow_d;

  logic accept;
  logic load;

  // Status outputs depend only on registered state.
  assign wr_index    = wr_ptr_q;
  assign rd_index    = rd_ptr_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CountFull);
  assign instr_out   = instr_q;
  assign instr_valid = (state_q == StHold);
  assign overflow    = overflow_q;

  // A write in the same edge as a load from full is rejected: accept sees the pre-edge full.
  assign accept = wr_en && !full;
  assign load   = !empty && (!instr_valid || instr_ready);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    overflow_d = overflow_q;

    if (flush) begin
      state_d  = StEmpty;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      unique case ({accept, load})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            state_d = StHold;
          end
        end
        StHold: begin
          if (!load && instr_ready) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
      if (load) begin
        instr_d  = buf_data;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_instr_buffer_reader.sv
// Directed bench for instr_buffer_reader with a behavioural instruction buffer and an
// in-order scoreboard for the random-ready wrap run.
module tb_instr_buffer_reader;

  localparam int unsigned W  = 16;
  localparam int unsigned BS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [3:0]    wr_index;
  logic [3:0]    rd_index;
  logic [W-1:0]  buf_data;
  logic [W-1:0]  instr_out;
  logic          instr_valid;
  logic          instr_ready;
  logic          flush;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic [W-1:0]  wdata;
  logic [W-1:0]  mem [BS];

  int n_cmp = 0;
  int n_err = 0;

  instr_buffer_reader #(
    .Instruction_word_size(W),
    .bs                   (BS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .rd_index   (rd_index),
    .buf_data   (buf_data),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .flush      (flush),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Buffer stores a word only when the reader would accept it.
  always @(posedge clk) begin
    if (!rst && !flush && wr_en && !full) mem[wr_index] <= wdata;
  end
  assign buf_data = mem[rd_index];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_valid"}, 32'(instr_valid), 0);
    check({tag, "_instr"}, 32'(instr_out), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_wri"}, 32'(wr_index), 0);
    check({tag, "_rdi"}, 32'(rd_index), 0);
  endtask

  logic [W-1:0] q[$];
  int sent, rcvd;
  logic wr_wrap, rd_wrap;
  logic [3:0] prev_wr, prev_rd;

  initial begin
    wdata = '0;
    do_reset();
    check_reset_state("rst");

    // Test 1: three consecutive writes, ready high.
    instr_ready = 1'b1;
    wr_en = 1'b1; wdata = 16'h1111; step();
    check("t1_cnt0", 32'(count), 1);
    check("t1_val0", 32'(instr_valid), 0);
    wdata = 16'h2222; step();
    check("t1_out1", 32'(instr_out), 32'h1111);
    check("t1_val1", 32'(instr_valid), 1);
    check("t1_cnt1", 32'(count), 1);
    wdata = 16'h3333; step();
    check("t1_out2", 32'(instr_out), 32'h2222);
    check("t1_cnt2", 32'(count), 1);
    wr_en = 1'b0; step();
    check("t1_out3", 32'(instr_out), 32'h3333);
    check("t1_val3", 32'(instr_valid), 1);
    check("t1_empty", 32'(empty), 1);
    step();
    check("t1_drop", 32'(instr_valid), 0);
    check("t1_hold", 32'(instr_out), 32'h3333);

    // Test 2: fill with ready low; one word sits in instr_out, bs in the buffer.
    do_reset();
    for (int i = 0; i <= int'(BS); i++) begin
      wr_en = 1'b1; wdata = 16'h2000 + 16'(i); step();
    end
    wr_en = 1'b0;
    check("t2_full", 32'(full), 1);
    check("t2_count", 32'(count), BS);
    check("t2_head", 32'(instr_out), 32'h2000);
    check("t2_valid", 32'(instr_valid), 1);
    check("t2_noovf", 32'(overflow), 0);
    wr_en = 1'b1; wdata = 16'hDEAD; step();
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_ovf", 32'(count), BS);
    check("t2_wri", 32'(wr_index), 1);
    check("t2_stall", 32'(instr_out), 32'h2000);

    // Test 3: drain; first edge also carries a write that must be rejected (pre-edge full).
    wdata = 16'hBEEF; instr_ready = 1'b1; step();
    wr_en = 1'b0;
    check("t3_rej_cnt", 32'(count), BS - 1);
    check("t3_rej_wri", 32'(wr_index), 1);
    check("t3_out_1", 32'(instr_out), 32'h2001);
    for (int k = 2; k <= int'(BS); k++) begin
      step();
      check("t3_out", 32'(instr_out), 32'(16'h2000 + 16'(k)));
    end
    check("t3_lastvalid", 32'(instr_valid), 1);
    step();
    check("t3_empty", 32'(empty), 1);
    check("t3_valid", 32'(instr_valid), 0);

    // Test 5: flush with count=5 while overflow is still set; same-cycle wr_en/ready ignored.
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wdata = 16'h5000 + 16'(i); step();
    end
    wr_en = 1'b0;
    check("t5_pre_cnt", 32'(count), 5);
    check("t5_pre_val", 32'(instr_valid), 1);
    flush = 1'b1; wr_en = 1'b1; instr_ready = 1'b1; wdata = 16'h5555; step();
    flush = 1'b0; wr_en = 1'b0; instr_ready = 1'b0;
    check("t5_cnt", 32'(count), 0);
    check("t5_val", 32'(instr_valid), 0);
    check("t5_wri", 32'(wr_index), 0);
    check("t5_rdi", 32'(rd_index), 0);
    check("t5_ovf", 32'(overflow), 1);
    check("t5_instr", 32'(instr_out), 32'h5000);

    // Test 4: 3*bs words with random ready, in-order scoreboard, pointer wrap.
    do_reset();
    q.delete();
    sent = 0; rcvd = 0; wr_wrap = 1'b0; rd_wrap = 1'b0;
    prev_wr = wr_index; prev_rd = rd_index;
    for (int cyc = 0; cyc < 2000 && rcvd < 3 * int'(BS); cyc++) begin
      wr_en = (sent < 3 * int'(BS)) && !full && ($urandom_range(0, 3) != 0);
      wdata = 16'h4000 + 16'(sent);
      if (wr_en) begin
        q.push_back(wdata);
        sent++;
      end
      instr_ready = 1'($urandom_range(0, 1));
      if (instr_valid && instr_ready) begin
        check("t4_order", 32'(instr_out), (q.size() > 0) ? 32'(q[0]) : 32'hFFFF_FFFF);
        if (q.size() > 0) void'(q.pop_front());
        rcvd++;
      end
      step();
      if (prev_wr == 4'd15 && wr_index == 4'd0) wr_wrap = 1'b1;
      if (prev_rd == 4'd15 && rd_index == 4'd0) rd_wrap = 1'b1;
      prev_wr = wr_index;
      prev_rd = rd_index;
    end
    wr_en = 1'b0; instr_ready = 1'b0;
    check("t4_received", 32'(rcvd), 3 * BS);
    check("t4_wr_wrap", 32'(wr_wrap), 1);
    check("t4_rd_wrap", 32'(rd_wrap), 1);

    // Test 6: simultaneous accept and load at count=4, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wdata = 16'h6000 + 16'(i); step();
    end
    check("t6_pre_cnt", 32'(count), 4);
    instr_ready = 1'b1; wdata = 16'h6005; step();
    check("t6_cnt", 32'(count), 4);
    check("t6_out", 32'(instr_out), 32'h6001);
    rst = 1'b1; step();
    rst = 1'b0; wr_en = 1'b0; instr_ready = 1'b0;
    check_reset_state("t6_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
